// File: rtl/rf_pkg.sv
// Shared definitions for the reg_file_mp register file.
//   rf_state_e  : clear-sequencer state encoding (RF_CLEAR, RF_RUN)
//   RF_CNT_W    : width of the debug write counter
//   RF_CNT_MAX  : saturation value of the debug write counter
//   rf_cnt_add  : saturating add used by the write counter
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int unsigned         RF_CNT_W   = 16;
  localparam logic [RF_CNT_W-1:0] RF_CNT_MAX = '1;

  function automatic logic [RF_CNT_W-1:0] rf_cnt_add(input logic [RF_CNT_W-1:0] cnt,
                                                      input logic [1:0]          inc);
    logic [RF_CNT_W:0] sum;
    sum = {1'b0, cnt} + (RF_CNT_W + 1)'(inc);
    if (sum > {1'b0, RF_CNT_MAX}) return RF_CNT_MAX;
    return sum[RF_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer for reg_file_mp: after reset, walks every entry once,
// asserting clr_we with clr_addr so the array writes zero, then enters RUN.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (restarts the sweep)
//   busy      : 1 while the sweep is in progress
//   clr_we    : write strobe for the zeroing write
//   clr_addr  : entry being zeroed this cycle
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] clr_idx, clr_idx_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    busy        = 1'b0;
    clr_we      = 1'b0;
    case (state)
      RF_CLEAR: begin
        busy        = 1'b1;
        clr_we      = ~rst;
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == LAST_IDX) state_nxt = RF_RUN;
      end
      default: ;
    endcase
  end

  assign clr_addr = clr_idx;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file for the ID stage: NUM_RD combinational read
// ports, two write ports (port 1 wins on address conflict), a clear
// sequencer that zeroes one entry per cycle after reset while busy=1,
// and a saturating debug count of committed writes.
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read bypass).
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   rd_addr / rd_data       : packed read ports, port k at slice k
//   we0/waddr0/wdata0       : write port 0 (low priority)
//   we1/waddr1/wdata1       : write port 1 (high priority)
//   busy                    : clear in progress; pipeline must stall
//   wr_cnt                  : saturating committed-write count
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  output logic                     busy,
  output logic [RF_CNT_W-1:0]      wr_cnt
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  rf_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Effective write enables: dropped while clearing/resetting and, with
  // ZERO_REG, for address 0.
  logic wr_ok, v0, v1;
  logic [1:0] wr_inc;

  always_comb begin
    wr_ok  = ~busy & ~rst;
    v0     = wr_ok & we0 & ~((ZERO_REG != 0) && (waddr0 == '0));
    v1     = wr_ok & we1 & ~((ZERO_REG != 0) && (waddr1 == '0));
    wr_inc = '0;
    if (v0 && v1 && (waddr0 == waddr1)) wr_inc = 2'd1;
    else                                wr_inc = {1'b0, v0} + {1'b0, v1};
  end

  // Port 1 is written after port 0 so it wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (v0) mem[waddr0] <= wdata0;
      if (v1) mem[waddr1] <= wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        wr_cnt <= '0;
    else if (!busy) wr_cnt <= rf_cnt_add(wr_cnt, wr_inc);
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = mem[ra];
`ifdef RF_BYPASS_EN
      if (v1 && (waddr1 == ra))      rd = wdata1;
      else if (v0 && (waddr0 == ra)) rd = wdata0;
`endif
      if (busy || ((ZERO_REG != 0) && (ra == '0))) rd = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nz;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic        busy, busy_nz;
  logic [15:0] wr_cnt, wr_cnt_nz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_mp #(
    .DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)
  ) u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .busy(busy), .wr_cnt(wr_cnt)
  );

  reg_file_mp #(
    .DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)
  ) u_dut_nz (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nz),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .busy(busy_nz), .wr_cnt(wr_cnt_nz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic no_wr();
    we0 = 1'b0; we1 = 1'b0;
    waddr0 = '0; waddr1 = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  initial begin
    int n;
    logic [31:0] bypass_exp;

    rst = 1'b1;
    rd_addr = '0;
    no_wr();
    tick();

    // Reset state
    check("reset_busy", {31'b0, busy}, 32'd1);
    check("reset_rd0", rd_data[31:0], 32'h0);
    check("reset_rd1", rd_data[63:32], 32'h0);
    check("reset_wr_cnt", {16'b0, wr_cnt}, 32'd0);

    // Clear length after a one-cycle reset
    rst = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    check("clear_cycles", n, 32'd32);
    check("nz_busy_done", {31'b0, busy_nz}, 32'd0);

    for (int unsigned i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      check("clear_rd0", rd_data[31:0], 32'h0);
      check("clear_nz_rd1", rd_data_nz[63:32], 32'h0);
    end
    check("clear_wr_cnt", {16'b0, wr_cnt}, 32'd0);

    // Basic write/read
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    tick();
    no_wr();
    set_rd(5'd5, 5'd6);
    check("basic_rd", rd_data[31:0], 32'hDEADBEEF);
    check("basic_rd_other", rd_data[63:32], 32'h0);
    check("basic_wr_cnt", {16'b0, wr_cnt}, 32'd1);

    // Same-address conflict: port 1 wins, counted once
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    tick();
    no_wr();
    set_rd(5'd7, 5'd5);
    check("conflict_rd", rd_data[31:0], 32'h22);
    check("conflict_keep5", rd_data[63:32], 32'hDEADBEEF);
    check("conflict_wr_cnt", {16'b0, wr_cnt}, 32'd2);

    // Different addresses: both commit, counted twice
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h33;
    we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h44;
    tick();
    no_wr();
    set_rd(5'd3, 5'd4);
    check("dual_rd3", rd_data[31:0], 32'h33);
    check("dual_rd4", rd_data[63:32], 32'h44);
    check("dual_wr_cnt", {16'b0, wr_cnt}, 32'd4);

    // x0 handling
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
    tick();
    no_wr();
    set_rd(5'd0, 5'd0);
    check("x0_rd", rd_data[31:0], 32'h0);
    check("x0_wr_cnt", {16'b0, wr_cnt}, 32'd4);
    check("nz_x0_rd", rd_data_nz[31:0], 32'hFFFF_FFFF);
    check("nz_wr_cnt", {16'b0, wr_cnt_nz}, 32'd5);

    // Same-cycle read of an entry being written
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h0000_A5A5;
    set_rd(5'd9, 5'd3);
`ifdef RF_BYPASS_EN
    bypass_exp = 32'h0000_A5A5;
`else
    bypass_exp = 32'h0;
`endif
    check("bypass_rd", rd_data[31:0], bypass_exp);
    check("bypass_other", rd_data[63:32], 32'h33);
    tick();
    no_wr();
    #1;
    check("bypass_after", rd_data[31:0], 32'h0000_A5A5);
    check("bypass_wr_cnt", {16'b0, wr_cnt}, 32'd5);

    // Reset mid-clear and busy gating
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_busy", {31'b0, busy}, 32'd1);
    check("rst2_wr_cnt", {16'b0, wr_cnt}, 32'd0);
    we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h1234_5678;
    for (int unsigned i = 0; i < 10; i++) tick();
    set_rd(5'd5, 5'd2);
    check("busy_rd_zero", rd_data[31:0], 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    we0 = 1'b0;
    #1;
    check("midclr_cycles", n, 32'd32);
    check("midclr_wr_cnt", {16'b0, wr_cnt}, 32'd0);
    check("midclr_rd5", rd_data[31:0], 32'h0);
    check("midclr_rd2", rd_data[63:32], 32'h0);
    set_rd(5'd9, 5'd7);
    check("midclr_rd9", rd_data[31:0], 32'h0);
    check("midclr_rd7", rd_data[63:32], 32'h0);
    tick();
    check("midclr_wr_cnt_run", {16'b0, wr_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
